// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer slice.
package alarm_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned TONE_W = 24;
  localparam int unsigned SNZ_W  = 2;

  localparam logic [TONE_W-1:0] TONE_A_DFLT = 24'd56818;
  localparam logic [TONE_W-1:0] TONE_B_DFLT = 24'd28409;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/alarm_sequencer_if.sv
// Timekeeping/user inputs and sound-stage outputs of the alarm sequencer.
interface alarm_sequencer_if import alarm_pkg::*; ();

  logic              tick1Hz;
  logic              alarmEnable;
  logic [HOUR_W-1:0] timeHour;
  logic [MIN_W-1:0]  timeMin;
  logic [SEC_W-1:0]  timeSec;
  logic [HOUR_W-1:0] alarmHour;
  logic [MIN_W-1:0]  alarmMin;
  logic              snoozeBtn;
  logic              stopBtn;
  logic              alarmActive;
  logic [TONE_W-1:0] toneBus;
  logic [SNZ_W-1:0]  snoozeCount;

  modport master (
    output tick1Hz, alarmEnable, timeHour, timeMin, timeSec,
           alarmHour, alarmMin, snoozeBtn, stopBtn,
    input  alarmActive, toneBus, snoozeCount
  );

  modport slave (
    input  tick1Hz, alarmEnable, timeHour, timeMin, timeSec,
           alarmHour, alarmMin, snoozeBtn, stopBtn,
    output alarmActive, toneBus, snoozeCount
  );

endinterface

// File: rtl/alarm_time_match.sv
// Registered wall-clock vs alarm comparator plus the matching one-cycle tick delay.
module alarm_time_match import alarm_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick1Hz,
  input  logic              enable,
  input  logic [HOUR_W-1:0] timeHour,
  input  logic [MIN_W-1:0]  timeMin,
  input  logic [SEC_W-1:0]  timeSec,
  input  logic [HOUR_W-1:0] alarmHour,
  input  logic [MIN_W-1:0]  alarmMin,
  output logic              matchNow,
  output logic              tickDly
);

  // Only an exact hh:mm:00 matches, so a jump past or into the minute never fires late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matchNow <= 1'b0;
      tickDly  <= 1'b0;
    end else begin
      matchNow <= enable && (timeHour == alarmHour) && (timeMin == alarmMin)
                  && (timeSec == SEC_W'(0));
      tickDly  <= tick1Hz;
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Ring / snooze / stop sequencer driving alarmActive and the tone word.
module alarm_sequencer import alarm_pkg::*; #(
  parameter int unsigned       RING_TIMEOUT_S = 60,
  parameter int unsigned       SNOOZE_S       = 300,
  parameter int unsigned       MAX_SNOOZE     = 3,
  parameter logic [TONE_W-1:0] TONE_A         = TONE_A_DFLT,
  parameter logic [TONE_W-1:0] TONE_B         = TONE_B_DFLT
) (
  input logic               clk,
  input logic               rst_n,
  alarm_sequencer_if.slave  bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SNZ_W-1:0]  snz_q, snz_d;
  logic              active_q, active_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic              match_now;
  logic              tick_dly;
  logic              trigger;

  alarm_time_match u_match (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick1Hz   (bus.tick1Hz),
    .enable    (bus.alarmEnable),
    .timeHour  (bus.timeHour),
    .timeMin   (bus.timeMin),
    .timeSec   (bus.timeSec),
    .alarmHour (bus.alarmHour),
    .alarmMin  (bus.alarmMin),
    .matchNow  (match_now),
    .tickDly   (tick_dly)
  );

  assign trigger = match_now & tick_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      snz_q    <= '0;
      active_q <= 1'b0;
      tone_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      snz_q    <= snz_d;
      active_q <= active_d;
      tone_q   <= tone_d;
    end
  end

  // Priority: disable > stop > snooze > tick-driven transitions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    snz_d    = snz_q;
    active_d = (state_q == RING);
    tone_d   = '0;
    if (state_q == RING) begin
      tone_d = cnt_q[0] ? TONE_B : TONE_A;
    end

    if (!bus.alarmEnable) begin
      state_d = IDLE;
      cnt_d   = '0;
      snz_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_d = RING;
            cnt_d   = '0;
          end
        end
        RING: begin
          if (bus.stopBtn) begin
            state_d = DONE;
            cnt_d   = '0;
          end else if (bus.snoozeBtn && (snz_q < SNZ_W'(MAX_SNOOZE))) begin
            state_d = SNOOZE;
            cnt_d   = CNT_W'(SNOOZE_S - 1);
            snz_d   = snz_q + SNZ_W'(1);
          end else if (bus.tick1Hz) begin
            if (cnt_q == CNT_W'(RING_TIMEOUT_S - 1)) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        SNOOZE: begin
          if (bus.stopBtn) begin
            state_d = DONE;
            cnt_d   = '0;
          end else if (bus.tick1Hz) begin
            if (cnt_q == '0) begin
              state_d = RING;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        DONE: begin
          // Hold until the alarm minute has passed so it cannot re-trigger.
          if (bus.timeMin != bus.alarmMin) begin
            state_d = IDLE;
            snz_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.alarmActive = active_q;
  assign bus.toneBus     = tone_q;
  assign bus.snoozeCount = snz_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with hand-computed expectations.
module tb_alarm_sequencer;
  import alarm_pkg::*;

  localparam logic [31:0] EXP_TONE_A = 32'd56818;
  localparam logic [31:0] EXP_TONE_B = 32'd28409;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_bad = 0;

  alarm_sequencer_if bus ();

  alarm_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus.timeHour = HOUR_W'(h);
    bus.timeMin  = MIN_W'(m);
    bus.timeSec  = SEC_W'(s);
  endtask

  // One tick pulse followed by two idle cycles so registered outputs settle.
  task automatic pulse_tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      bus.tick1Hz = 1'b1;
      step();
      bus.tick1Hz = 1'b0;
      step(2);
    end
  endtask

  task automatic press(input logic snz, input logic stp);
    bus.snoozeBtn = snz;
    bus.stopBtn   = stp;
    step();
    bus.snoozeBtn = 1'b0;
    bus.stopBtn   = 1'b0;
    step(2);
  endtask

  task automatic fire_alarm();
    set_time(7, 29, 59);
    pulse_tick();
    set_time(7, 30, 0);
    pulse_tick();
    set_time(7, 30, 1);
  endtask

  task automatic chk_active(input string tag, input logic exp);
    check(tag, 32'(bus.alarmActive), 32'(exp));
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.tick1Hz     = 1'b0;
    bus.alarmEnable = 1'b1;
    bus.snoozeBtn   = 1'b0;
    bus.stopBtn     = 1'b0;
    bus.alarmHour   = HOUR_W'(7);
    bus.alarmMin    = MIN_W'(30);
    set_time(7, 29, 0);
    step(3);
    check("rst_active", 32'(bus.alarmActive), 32'd0);
    check("rst_tone",   32'(bus.toneBus),     32'd0);
    check("rst_snz",    32'(bus.snoozeCount), 32'd0);
    rst_n = 1'b1;
    step(2);

    // 1: trigger at 07:30:00, tone alternates per tick
    set_time(7, 29, 59);
    pulse_tick();
    chk_active("t1_pre", 1'b0);
    set_time(7, 30, 0);
    pulse_tick();
    chk_active("t1_ring", 1'b1);
    check("t1_toneA", 32'(bus.toneBus), EXP_TONE_A);
    set_time(7, 30, 1);
    pulse_tick();
    check("t1_toneB", 32'(bus.toneBus), EXP_TONE_B);

    // 2: snooze, then back to ringing after 300 ticks
    press(1'b1, 1'b0);
    chk_active("t2_snoozed", 1'b0);
    check("t2_snz1", 32'(bus.snoozeCount), 32'd1);
    check("t2_tone0", 32'(bus.toneBus), 32'd0);
    pulse_tick(299);
    chk_active("t2_tick299", 1'b0);
    pulse_tick();
    chk_active("t2_tick300", 1'b1);
    check("t2_toneA", 32'(bus.toneBus), EXP_TONE_A);

    // 3: exhaust snoozes, fourth press ignored, stop
    press(1'b1, 1'b0);
    pulse_tick(300);
    press(1'b1, 1'b0);
    pulse_tick(300);
    chk_active("t3_ring3", 1'b1);
    check("t3_snz3", 32'(bus.snoozeCount), 32'd3);
    press(1'b1, 1'b0);
    chk_active("t3_snz4_ignored", 1'b1);
    check("t3_snz_still3", 32'(bus.snoozeCount), 32'd3);
    press(1'b0, 1'b1);
    chk_active("t3_stop", 1'b0);
    check("t3_stop_tone", 32'(bus.toneBus), 32'd0);

    // 4: leave DONE on new minute, then 60-tick timeout
    set_time(7, 31, 1);
    step(3);
    check("t4_idle_snz0", 32'(bus.snoozeCount), 32'd0);
    fire_alarm();
    chk_active("t4_ring", 1'b1);
    pulse_tick(59);
    chk_active("t4_tick59", 1'b1);
    pulse_tick();
    chk_active("t4_tick60", 1'b0);
    set_time(7, 30, 0);
    pulse_tick();
    chk_active("t4_no_retrigger", 1'b0);
    set_time(7, 31, 0);
    pulse_tick();
    set_time(7, 30, 0);
    pulse_tick();
    chk_active("t4_rearmed", 1'b1);

    // 5: snooze and stop together -> stop wins
    press(1'b1, 1'b1);
    chk_active("t5_done", 1'b0);
    check("t5_snz0", 32'(bus.snoozeCount), 32'd0);
    pulse_tick(5);
    chk_active("t5_stays_done", 1'b0);

    // 6: asynchronous reset mid-ring, then disable mid-snooze
    set_time(7, 31, 0);
    step(2);
    fire_alarm();
    chk_active("t6_ring", 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_active("t6_async_active", 1'b0);
    check("t6_async_tone", 32'(bus.toneBus), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    fire_alarm();
    chk_active("t6_ring2", 1'b1);
    press(1'b1, 1'b0);
    check("t6_snz1", 32'(bus.snoozeCount), 32'd1);
    bus.alarmEnable = 1'b0;
    step(2);
    check("t6_dis_snz0", 32'(bus.snoozeCount), 32'd0);
    chk_active("t6_dis_active", 1'b0);
    pulse_tick(300);
    chk_active("t6_dis_no_ring", 1'b0);
    bus.alarmEnable = 1'b1;

    // Midnight alarm and time jumps
    bus.alarmHour = HOUR_W'(0);
    bus.alarmMin  = MIN_W'(0);
    set_time(23, 59, 59);
    pulse_tick();
    set_time(0, 0, 0);
    pulse_tick();
    chk_active("mid_ring", 1'b1);
    press(1'b0, 1'b1);
    bus.alarmHour = HOUR_W'(7);
    bus.alarmMin  = MIN_W'(30);
    step(2);
    set_time(7, 29, 50);
    pulse_tick();
    set_time(7, 31, 0);
    pulse_tick();
    chk_active("jump_past", 1'b0);
    set_time(7, 30, 5);
    pulse_tick(2);
    chk_active("jump_into", 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
